spi_cmd_arbiter: RTL and testbench

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/spi_cmd_arbiter_pkg.sv | 22 ++
 rtl/spi_cmd_arbiter_rr.sv | 27 ++
 rtl/spi_cmd_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared types and engine command-field constants for the SPI command arbiter.
package spi_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RISE,
    WAIT_FALL,
    DONE
  } state_t;

  localparam int          BUSY_BIT         = 31;
  localparam logic [31:0] CMD_OP24         = 32'h8000_0000;
  localparam logic [31:0] CMD_LSB_FIRST    = 32'h4000_0000;
  localparam int          CMD_DEVSEL_SHIFT = 24;
  localparam logic [31:0] CMD_DEVSEL_MASK  = 32'h0F00_0000;

  function automatic logic is_busy(input logic [31:0] status);
    return status[BUSY_BIT];
  endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr.sv
// Round-robin winner search: scans upward from last+1, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            found
);

  int cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last) + off) % NREQ;
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI engine among NREQ requesters, one command at a time.
// Optional macro SPI_CMD_ARBITER_TIMEOUT_EN adds a busy-phase timeout.
//
// state     | meaning
// IDLE      | wait for any req_valid, latch winner, ack it
// ISSUE     | strobe the engine once (held off while BUSY is seen)
// WAIT_RISE | wait up to BUSY_RISE_CYCLES for BUSY to rise
// WAIT_FALL | wait for BUSY to fall (or timeout when enabled)
// DONE      | pulse rsp_valid with the status snapshot
module spi_cmd_arbiter
  import spi_cmd_arbiter_pkg::*;
#(
  parameter int NREQ             = 4,
  parameter int BUSY_RISE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*32-1:0]      req_cmd,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_timeout,
  output logic                    spi_strobe,
  output logic [31:0]             spi_cmd,
  input  logic [31:0]             spi_status,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);
  localparam int RW = $clog2(BUSY_RISE_CYCLES + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("spi_cmd_arbiter: NREQ must be 2..8");
  end
  if (BUSY_RISE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("spi_cmd_arbiter: cycle parameters must be >= 1");
  end

  state_t        state;
  logic [RW-1:0] rise_cnt;
  logic          first_grant;
  logic [IW-1:0] rr_last;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          busy;

  assign busy = is_busy(spi_status);

  // Pretending the last grant was NREQ-1 makes the first search start at 0.
  assign rr_last = first_grant ? IW'(NREQ - 1) : grant_id;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req    (req_valid),
    .last   (rr_last),
    .winner (win_idx),
    .found  (win_found)
  );

`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          timed_out;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      spi_strobe  <= 1'b0;
      spi_cmd     <= '0;
      grant_id    <= '0;
      rise_cnt    <= '0;
      first_grant <= 1'b1;
`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
      timed_out   <= 1'b0;
`endif
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      spi_strobe <= 1'b0;
`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            spi_cmd     <= req_cmd[32*win_idx +: 32];
            grant_id    <= win_idx;
            req_ack     <= NREQ'(1) << win_idx;
            first_grant <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!busy) begin
            spi_strobe <= 1'b1;
            rise_cnt   <= RW'(BUSY_RISE_CYCLES);
            state      <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (busy) begin
            state <= WAIT_FALL;
`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
            to_cnt <= TW'(TIMEOUT_CYCLES);
`endif
          end else if (rise_cnt <= RW'(1)) begin
            state <= DONE;
          end else begin
            rise_cnt <= rise_cnt - RW'(1);
          end
        end
        WAIT_FALL: begin
          if (!busy) begin
            state <= DONE;
          end
`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
          else if (to_cnt <= TW'(1)) begin
            timed_out <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
`endif
        end
        DONE: begin
          rsp_valid <= NREQ'(1) << grant_id;
          rsp_data  <= spi_status;
          state     <= IDLE;
`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
          rsp_timeout <= timed_out;
          timed_out   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter with a behavioural engine and arbitration model.
module tb_spi_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int BRC  = 4;
  localparam int TO   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_cmd;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_timeout;
  logic                spi_strobe;
  logic [31:0]         spi_cmd;
  logic [31:0]         spi_status;
  logic [1:0]          grant_id;

  spi_cmd_arbiter #(.NREQ(NREQ), .BUSY_RISE_CYCLES(BRC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .spi_strobe(spi_strobe), .spi_cmd(spi_cmd),
    .spi_status(spi_status), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine: on a strobe it stays busy for eng_len cycles.
  int          eng_left = 0;
  int          eng_len  = 0;
  logic [30:0] status_lo = '0;
  int          strobe_cnt = 0;
  bit          strobe_busy = 1'b0;
  always @(posedge clk) begin
    if (spi_strobe) eng_left <= eng_len;
    else if (eng_left > 0) eng_left <= eng_left - 1;
    if (spi_strobe) strobe_cnt <= strobe_cnt + 1;
    if (spi_strobe && spi_status[31]) strobe_busy <= 1'b1;
  end
  assign spi_status = {(eng_left > 0), status_lo};

  int checks = 0;
  int errors = 0;
  int model_last = 0;
  bit model_first = 1'b1;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    int start;
    start = model_first ? 0 : (model_last + 1) % NREQ;
    for (int i = 0; i < NREQ; i++)
      if (mask[(start + i) % NREQ]) return (start + i) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_first = 1'b1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check(req_ack, 0, {pfx, "_req_ack"});
    check(rsp_valid, 0, {pfx, "_rsp_valid"});
    check(spi_strobe, 0, {pfx, "_strobe"});
    check(rsp_timeout, 0, {pfx, "_rsp_timeout"});
    check(spi_cmd, 0, {pfx, "_spi_cmd"});
    check(rsp_data, 0, {pfx, "_rsp_data"});
    check(grant_id, 0, {pfx, "_grant_id"});
  endtask

  // Raises mask, expects the model's winner; returns the ack cycle and winner.
  task automatic start_xfer(input logic [NREQ-1:0] mask, input int len, input bit use_fixed,
                            input logic [31:0] fixed_cmd, output int w, output int a_cyc,
                            output bit ok);
    logic [31:0] cmds [NREQ];
    int t;
    w = model_pick(mask);
    for (int i = 0; i < NREQ; i++) begin
      cmds[i] = (use_fixed && i == w) ? fixed_cmd : $urandom;
      req_cmd[32*i +: 32] = cmds[i];
    end
    eng_len   = len;
    status_lo = 31'($urandom);
    req_valid = mask;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 20) begin
      @(posedge clk); #1;
      t++;
      if (req_ack != 0) ok = 1'b1;
    end
    check(t, 1, "ack_latency");
    a_cyc = cyc;
    if (!ok) begin
      req_valid = '0;
      return;
    end
    check(req_ack, 32'(1) << w, "req_ack");
    check(grant_id, w, "grant_id");
    check(spi_cmd, cmds[w], "spi_cmd");
    req_valid[w] = 1'b0;
    @(posedge clk); #1;
    check(spi_strobe, 1, "strobe_slot");
    model_last  = w;
    model_first = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output bit got);
    int t;
    got = 1'b0;
    t   = 0;
    while (!got && t < bound) begin
      @(posedge clk); #1;
      t++;
      if (rsp_valid != 0) got = 1'b1;
    end
    check(got, 1, "rsp_seen");
  endtask

  task automatic xfer(input logic [NREQ-1:0] mask, input int len, input bit use_fixed,
                      input logic [31:0] fixed_cmd);
    int w, a_cyc, s0;
    bit ok;
    s0 = strobe_cnt;
    start_xfer(mask, len, use_fixed, fixed_cmd, w, a_cyc, ok);
    if (!ok) return;
    wait_rsp(200, ok);
    if (!ok) return;
    // Zero-length: rsp BRC+2 after ack; otherwise BUSY lasts len cycles starting ack+2.
    check(cyc - a_cyc, (len == 0) ? BRC + 2 : len + 4, "rsp_latency");
    check(rsp_valid, 32'(1) << w, "rsp_valid");
    check(rsp_timeout, 0, "rsp_timeout");
    check(rsp_data, {1'b0, status_lo}, "rsp_data");
    check(strobe_cnt - s0, 1, "strobe_count");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a_cyc, nrsp;
    bit ok;
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Requester 0, fixed command, engine busy 16 cycles.
    xfer(4'b0001, 16, 1'b1, 32'h4000_07AA);

    // All four held valid from reset: order 0,1,2,3,0.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      check(model_pick(4'b1111), n % NREQ, "rr_order_model");
      xfer(4'b1111, 3 + n, 1'b0, 32'h0);
    end

    // BUSY never rises.
    xfer(4'b0100, 0, 1'b0, 32'h0);

    // Randomized masks and transfer lengths.
    for (int n = 0; n < 24; n++)
      xfer(NREQ'($urandom_range(1, 15)), $urandom_range(0, 12), 1'b0, 32'h0);

    // Engine stuck busy.
`ifdef SPI_CMD_ARBITER_TIMEOUT_EN
    start_xfer(4'b0100, 200, 1'b0, 32'h0, w, a_cyc, ok);
    if (ok) begin
      wait_rsp(100, ok);
      if (ok) begin
        check(cyc - a_cyc, TO + 4, "timeout_latency");
        check(rsp_valid, 32'(1) << w, "timeout_rsp_valid");
        check(rsp_timeout, 1, "timeout_flag");
        check(rsp_data[31], 1, "timeout_busy_bit");
      end
      for (int t = 0; t < 400 && eng_left > 0; t++) @(posedge clk);
      #1;
    end
`else
    start_xfer(4'b0100, 1100, 1'b0, 32'h0, w, a_cyc, ok);
    if (ok) begin
      nrsp = 0;
      for (int t = 0; t < 1000; t++) begin
        @(posedge clk); #1;
        if (rsp_valid != 0) nrsp++;
      end
      check(nrsp, 0, "no_timeout_rsp_count");
      wait_rsp(300, ok);
      if (ok) begin
        check(cyc - a_cyc, 1100 + 4, "long_busy_latency");
        check(rsp_timeout, 0, "long_busy_timeout");
      end
    end
`endif

    // Reset asserted in WAIT_FALL.
    start_xfer(4'b0010, 30, 1'b0, 32'h0, w, a_cyc, ok);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_first = 1'b1;
    nrsp = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (rsp_valid != 0) nrsp++;
    end
    check(nrsp, 0, "abandoned_rsp_count");
    xfer(4'b1110 | 4'b0001, 5, 1'b0, 32'h0);
    check(model_last, 0, "post_reset_grant_model");
    check(grant_id, 0, "post_reset_grant_id");

    check(strobe_busy, 0, "strobe_while_busy");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
